// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared FSM state type and memory-stage constants
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } mem_state_e;

   localparam logic [7:0] TIMEOUT_DEFAULT = 8'd255;
   localparam logic [1:0] BE_WORD         = 2'b11;
   localparam logic [1:0] BE_LO           = 2'b01;
   localparam logic [1:0] BE_HI           = 2'b10;

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data memory request/response bus between mem_stage and memory
interface mem_stage_if;

   logic        dmem_req;
   logic        dmem_we;
   logic [15:0] dmem_addr;
   logic [15:0] dmem_wdata;
   logic [1:0]  dmem_be;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [15:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_gnt, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_gnt, dmem_rvalid, dmem_rdata
   );

endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering for stores and byte extraction for loads
module mem_lane_align
   import cpu_pkg::*;
(
   input  logic        st_addr0,
   input  logic        st_byte,
   input  logic [15:0] st_data,
   output logic [15:0] st_wdata,
   output logic [1:0]  st_be,
   input  logic        ld_addr0,
   input  logic        ld_byte,
   input  logic [15:0] ld_rdata,
   output logic [15:0] ld_data
);

   // byte stores replicate the low byte on both lanes; byte loads zero-extend the addressed lane
   always_comb begin
      st_wdata = st_data;
      st_be    = BE_WORD;
      ld_data  = ld_rdata;
      if (st_byte) begin
         st_wdata = {st_data[7:0], st_data[7:0]};
         st_be    = st_addr0 ? BE_HI : BE_LO;
      end
      if (ld_byte) begin
         ld_data = {8'h00, (ld_addr0 ? ld_rdata[15:8] : ld_rdata[7:0])};
      end
   end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: ALU passthrough, load/store bus sequencing, writeback
module mem_stage
   import cpu_pkg::*;
#(
   parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ex2_valid,
   input  logic [15:0]  ex2_alu_out,
   input  logic [15:0]  ex2_rs2,
   input  logic [3:0]   ex2_rd,
   input  logic         ex2_ld,
   input  logic         ex2_st,
   input  logic         ex2_byte,
   mem_stage_if.master  dmem,
   output logic         stall,
   output logic         wb_valid,
   output logic         wb_we,
   output logic [3:0]   wb_rd,
   output logic [15:0]  wb_data,
   output logic         misalign,
   output logic         bus_err
);

   mem_state_e  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [1:0]  be_q, be_d;
   logic        we_q, we_d;
   logic        byte_q, byte_d;
   logic [3:0]  rd_q, rd_d;
   logic        wb_valid_q, wb_valid_d;
   logic        wb_we_q, wb_we_d;
   logic [3:0]  wb_rd_q, wb_rd_d;
   logic [15:0] wb_data_q, wb_data_d;
   logic        misalign_q, misalign_d;
   logic        bus_err_q, bus_err_d;

   logic [15:0] lane_wdata;
   logic [1:0]  lane_be;
   logic [15:0] lane_ld_data;
   logic        mem_op;
   logic        unaligned;
   logic        timed_out;
   logic [7:0]  cnt_inc;

   mem_lane_align u_lane (
      .st_addr0 (ex2_alu_out[0]),
      .st_byte  (ex2_byte),
      .st_data  (ex2_rs2),
      .st_wdata (lane_wdata),
      .st_be    (lane_be),
      .ld_addr0 (addr_q[0]),
      .ld_byte  (byte_q),
      .ld_rdata (dmem.dmem_rdata),
      .ld_data  (lane_ld_data)
   );

   assign mem_op    = ex2_ld | ex2_st;
   assign unaligned = ~ex2_byte & ex2_alu_out[0];
   assign timed_out = (cnt_q == TIMEOUT);
   // saturate so a late grant near the limit cannot wrap the wait budget
   assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

   // next-state, capture and writeback pulse generation; rvalid is only looked at in WAIT
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      we_d       = we_q;
      byte_d     = byte_q;
      rd_d       = rd_q;
      wb_valid_d = 1'b0;
      wb_we_d    = 1'b0;
      wb_rd_d    = 4'd0;
      wb_data_d  = 16'd0;
      misalign_d = 1'b0;
      bus_err_d  = 1'b0;
      stall      = 1'b0;
      case (state_q)
         IDLE: begin
            if (ex2_valid) begin
               if (!mem_op) begin
                  wb_valid_d = 1'b1;
                  wb_we_d    = (ex2_rd != 4'd0);
                  wb_rd_d    = ex2_rd;
                  wb_data_d  = ex2_alu_out;
               end else if (unaligned) begin
                  wb_valid_d = 1'b1;
                  misalign_d = 1'b1;
               end else begin
                  stall   = 1'b1;
                  state_d = REQ;
                  cnt_d   = 8'd0;
                  addr_d  = ex2_alu_out;
                  wdata_d = lane_wdata;
                  be_d    = lane_be;
                  we_d    = ex2_st & ~ex2_ld;
                  byte_d  = ex2_byte;
                  rd_d    = ex2_rd;
               end
            end
         end
         REQ: begin
            cnt_d = cnt_inc;
            if (dmem.dmem_gnt) begin
               if (we_q) begin
                  state_d    = IDLE;
                  wb_valid_d = 1'b1;
               end else begin
                  stall   = 1'b1;
                  state_d = WAIT;
               end
            end else if (timed_out) begin
               state_d    = IDLE;
               wb_valid_d = 1'b1;
               bus_err_d  = 1'b1;
            end else begin
               stall = 1'b1;
            end
         end
         WAIT: begin
            cnt_d = cnt_inc;
            if (dmem.dmem_rvalid) begin
               state_d    = IDLE;
               wb_valid_d = 1'b1;
               wb_we_d    = (rd_q != 4'd0);
               wb_rd_d    = rd_q;
               wb_data_d  = lane_ld_data;
            end else if (timed_out) begin
               state_d    = IDLE;
               wb_valid_d = 1'b1;
               bus_err_d  = 1'b1;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state, captured request and writeback registers; reset abandons any transaction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 8'd0;
         addr_q     <= 16'd0;
         wdata_q    <= 16'd0;
         be_q       <= 2'b00;
         we_q       <= 1'b0;
         byte_q     <= 1'b0;
         rd_q       <= 4'd0;
         wb_valid_q <= 1'b0;
         wb_we_q    <= 1'b0;
         wb_rd_q    <= 4'd0;
         wb_data_q  <= 16'd0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         we_q       <= we_d;
         byte_q     <= byte_d;
         rd_q       <= rd_d;
         wb_valid_q <= wb_valid_d;
         wb_we_q    <= wb_we_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         misalign_q <= misalign_d;
         bus_err_q  <= bus_err_d;
      end
   end

   assign dmem.dmem_req   = (state_q == REQ);
   assign dmem.dmem_we    = we_q;
   assign dmem.dmem_addr  = addr_q;
   assign dmem.dmem_wdata = wdata_q;
   assign dmem.dmem_be    = be_q;

   assign wb_valid = wb_valid_q;
   assign wb_we    = wb_we_q;
   assign wb_rd    = wb_rd_q;
   assign wb_data  = wb_data_q;
   assign misalign = misalign_q;
   assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed plus randomized bench for mem_stage against a memory-level model
module tb_mem_stage;

   localparam int TO = 255;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex2_valid;
   logic [15:0] ex2_alu_out;
   logic [15:0] ex2_rs2;
   logic [3:0]  ex2_rd;
   logic        ex2_ld;
   logic        ex2_st;
   logic        ex2_byte;
   logic        stall;
   logic        wb_valid;
   logic        wb_we;
   logic [3:0]  wb_rd;
   logic [15:0] wb_data;
   logic        misalign;
   logic        bus_err;

   mem_stage_if dmem_bus ();

   mem_stage dut (
      .clk         (clk),
      .rst         (rst),
      .ex2_valid   (ex2_valid),
      .ex2_alu_out (ex2_alu_out),
      .ex2_rs2     (ex2_rs2),
      .ex2_rd      (ex2_rd),
      .ex2_ld      (ex2_ld),
      .ex2_st      (ex2_st),
      .ex2_byte    (ex2_byte),
      .dmem        (dmem_bus),
      .stall       (stall),
      .wb_valid    (wb_valid),
      .wb_we       (wb_we),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .misalign    (misalign),
      .bus_err     (bus_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [int];

   logic [15:0] e_addr;
   logic [15:0] e_wdata;
   logic        e_we;
   logic [1:0]  e_be;

   logic        wbn_v, wbn_we, wbn_mis, wbn_err, wbn_full;
   logic [3:0]  wbn_rd;
   logic [15:0] wbn_data;
   logic        wbx_v, wbx_we, wbx_mis, wbx_err, wbx_full;
   logic [3:0]  wbx_rd;
   logic [15:0] wbx_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_wbn();
      wbn_v = 1'b0; wbn_we = 1'b0; wbn_mis = 1'b0; wbn_err = 1'b0; wbn_full = 1'b0;
      wbn_rd = 4'd0; wbn_data = 16'd0;
   endtask

   function automatic logic [15:0] mem_rd(input logic [15:0] a);
      int idx = int'(a[15:1]);
      if (mem.exists(idx)) return mem[idx];
      return {a[8:1] ^ 8'h5A, a[8:1]};
   endfunction

   task automatic mem_store(input logic [15:0] a, input logic [15:0] d, input logic byt);
      logic [15:0] w;
      w = mem_rd(a);
      if (!byt)      w = d;
      else if (a[0]) w[15:8] = d[7:0];
      else           w[7:0] = d[7:0];
      mem[int'(a[15:1])] = w;
   endtask

   // one clock: check this cycle's outputs at the falling edge, then advance expectations
   task automatic cyc(input logic es, input logic er);
      @(negedge clk);
      chk("stall", stall, es);
      chk("dmem_req", dmem_bus.dmem_req, er);
      if (er) begin
         chk("dmem_addr", dmem_bus.dmem_addr, e_addr);
         chk("dmem_we", dmem_bus.dmem_we, e_we);
         chk("dmem_wdata", dmem_bus.dmem_wdata, e_wdata);
         chk("dmem_be", dmem_bus.dmem_be, e_be);
      end
      chk("wb_valid", wb_valid, wbx_v);
      chk("misalign", misalign, wbx_mis);
      chk("bus_err", bus_err, wbx_err);
      if (wbx_v) chk("wb_we", wb_we, wbx_we);
      if (wbx_full) begin
         chk("wb_rd", wb_rd, wbx_rd);
         chk("wb_data", wb_data, wbx_data);
      end
      wbx_v = wbn_v; wbx_we = wbn_we; wbx_mis = wbn_mis; wbx_err = wbn_err;
      wbx_full = wbn_full; wbx_rd = wbn_rd; wbx_data = wbn_data;
      clear_wbn();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ex2_valid   = 1'b0;
      ex2_ld      = 1'($urandom);
      ex2_st      = 1'($urandom);
      ex2_alu_out = 16'($urandom);
      dmem_bus.dmem_gnt    = 1'b0;
      dmem_bus.dmem_rvalid = 1'($urandom);
      dmem_bus.dmem_rdata  = 16'($urandom);
      cyc(1'b0, 1'b0);
      dmem_bus.dmem_rvalid = 1'b0;
   endtask

   // issue one instruction and play the memory: gd = REQ cycles before grant,
   // rdl = WAIT cycles before rvalid; negative means the memory never answers
   task automatic do_op(input logic ld, input logic st, input logic byt, input logic [15:0] a,
                        input logic [15:0] d, input logic [3:0] rd, input int gd, input int rdl);
      int k;
      int j;
      int phase;
      logic done;
      logic [15:0] w;
      ex2_valid = 1'b1; ex2_ld = ld; ex2_st = st; ex2_byte = byt;
      ex2_alu_out = a; ex2_rs2 = d; ex2_rd = rd;
      dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0;
      if (!ld && !st) begin
         wbn_v = 1'b1; wbn_we = (rd != 4'd0); wbn_full = 1'b1; wbn_rd = rd; wbn_data = a;
         cyc(1'b0, 1'b0);
      end else if (!byt && a[0]) begin
         wbn_v = 1'b1; wbn_mis = 1'b1;
         cyc(1'b0, 1'b0);
      end else begin
         e_addr  = a;
         e_we    = st && !ld;
         e_be    = !byt ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
         e_wdata = byt ? {d[7:0], d[7:0]} : d;
         cyc(1'b1, 1'b0);
         k = 0; j = 0; phase = 0; done = 1'b0;
         while (!done) begin
            if (phase == 0) begin
               dmem_bus.dmem_gnt    = (j == gd);
               dmem_bus.dmem_rvalid = 1'($urandom);
               dmem_bus.dmem_rdata  = 16'($urandom);
               if (j == gd && !ld) begin
                  mem_store(a, d, byt);
                  wbn_v = 1'b1;
                  cyc(1'b0, 1'b1);
                  done = 1'b1;
               end else if (j == gd) begin
                  cyc(1'b1, 1'b1);
                  phase = 1; j = 0;
               end else if (k == TO) begin
                  wbn_v = 1'b1; wbn_err = 1'b1;
                  cyc(1'b0, 1'b1);
                  done = 1'b1;
               end else begin
                  cyc(1'b1, 1'b1);
                  j++;
               end
            end else begin
               dmem_bus.dmem_gnt    = 1'b0;
               dmem_bus.dmem_rvalid = (j == rdl);
               dmem_bus.dmem_rdata  = (j == rdl) ? mem_rd(a) : 16'($urandom);
               if (j == rdl) begin
                  w = mem_rd(a);
                  wbn_v = 1'b1; wbn_we = (rd != 4'd0); wbn_full = 1'b1; wbn_rd = rd;
                  wbn_data = byt ? ((w >> (8 * a[0])) & 16'h00FF) : w;
                  cyc(1'b0, 1'b0);
                  done = 1'b1;
               end else if (k == TO) begin
                  wbn_v = 1'b1; wbn_err = 1'b1;
                  cyc(1'b0, 1'b0);
                  done = 1'b1;
               end else begin
                  cyc(1'b1, 1'b0);
                  j++;
               end
            end
            k++;
         end
      end
      dmem_bus.dmem_gnt = 1'b0;
      dmem_bus.dmem_rvalid = 1'b0;
   endtask

   initial begin
      int kind;
      logic [15:0] ra;
      rst = 1'b1;
      ex2_valid = 1'b0; ex2_ld = 1'b0; ex2_st = 1'b0; ex2_byte = 1'b0;
      ex2_alu_out = 16'd0; ex2_rs2 = 16'd0; ex2_rd = 4'd0;
      dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = 16'd0;
      clear_wbn();
      wbx_v = 1'b0; wbx_we = 1'b0; wbx_mis = 1'b0; wbx_err = 1'b0; wbx_full = 1'b0;
      wbx_rd = 4'd0; wbx_data = 16'd0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_dmem_req", dmem_bus.dmem_req, 1'b0);
      chk("rst_dmem_we", dmem_bus.dmem_we, 1'b0);
      chk("rst_dmem_addr", dmem_bus.dmem_addr, 16'd0);
      chk("rst_dmem_wdata", dmem_bus.dmem_wdata, 16'd0);
      chk("rst_dmem_be", dmem_bus.dmem_be, 2'b00);
      chk("rst_wb_valid", wb_valid, 1'b0);
      chk("rst_wb_we", wb_we, 1'b0);
      chk("rst_wb_rd", wb_rd, 4'd0);
      chk("rst_wb_data", wb_data, 16'd0);
      chk("rst_misalign", misalign, 1'b0);
      chk("rst_bus_err", bus_err, 1'b0);
      chk("rst_stall", stall, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle();

      do_op(1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 4'd3, -1, -1);
      mem[int'(16'h0040 >> 1)] = 16'hBEEF;
      do_op(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 4'd7, 2, 2);
      mem[int'(16'h0011 >> 1)] = 16'h12A5;
      do_op(1'b0, 1'b1, 1'b1, 16'h0011, 16'h00A5, 4'd0, 1, -1);
      do_op(1'b1, 1'b0, 1'b1, 16'h0011, 16'h0000, 4'd4, 0, 0);
      do_op(1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000, 4'd2, 0, 0);
      do_op(1'b1, 1'b1, 0, 16'h0040, 16'h5555, 4'd9, 0, 1);
      do_op(1'b0, 1'b0, 1'b0, 16'h0077, 16'h0000, 4'd0, -1, -1);
      idle();
      do_op(1'b1, 1'b0, 1'b0, 16'h0060, 16'h0000, 4'd6, 0, -1);
      do_op(1'b0, 1'b1, 1'b0, 16'h0062, 16'hCAFE, 4'd0, -1, -1);
      idle();

      // reset while a load sits in WAIT, then a stray rvalid after release
      ex2_valid = 1'b1; ex2_ld = 1'b1; ex2_st = 1'b0; ex2_byte = 1'b0;
      ex2_alu_out = 16'h0080; ex2_rd = 4'd5;
      e_addr = 16'h0080; e_we = 1'b0; e_be = 2'b11; e_wdata = ex2_rs2;
      cyc(1'b1, 1'b0);
      dmem_bus.dmem_gnt = 1'b1;
      cyc(1'b1, 1'b1);
      dmem_bus.dmem_gnt = 1'b0;
      cyc(1'b1, 1'b0);
      ex2_valid = 1'b0;
      rst = 1'b1;
      #2;
      chk("async_rst_req", dmem_bus.dmem_req, 1'b0);
      chk("async_rst_stall", stall, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      dmem_bus.dmem_rvalid = 1'b1;
      dmem_bus.dmem_rdata  = 16'h1111;
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      dmem_bus.dmem_rvalid = 1'b0;

      repeat (150) begin
         kind = $urandom_range(0, 6);
         ra   = 16'h0100 + 16'($urandom_range(0, 15));
         case (kind)
            0: do_op(1'b0, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 4'($urandom), -1, -1);
            1: do_op(1'b1, 1'b0, 1'b0, ra, 16'($urandom), 4'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 3));
            2: do_op(1'b0, 1'b1, 1'b0, ra, 16'($urandom), 4'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 3));
            3: do_op(1'b1, 1'b0, 1'b1, ra, 16'($urandom), 4'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 3));
            4: do_op(1'b0, 1'b1, 1'b1, ra, 16'($urandom), 4'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 3));
            5: do_op(1'b1, 1'b1, 1'($urandom), ra, 16'($urandom), 4'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 3));
            default: idle();
         endcase
      end
      idle();
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
